uart_rx_frame: RTL and testbench



---
 rtl/uart_rx_frame_pkg.sv | 30 +++
 rtl/uart_bit_timer.sv | 32 +++
 rtl/uart_rx_frame.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the parametrised UART blocks: parity encodings,
// receiver state encoding and a constant clog2 for sizing counters.
package uart_rx_frame_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer shared by the UART receive and transmit paths: free-runs
// from a clear, wraps every CLK_PER_BIT cycles, flags the half- and full-bit points.
module uart_bit_timer #(
    parameter int CLK_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);
    import uart_rx_frame_pkg::*;

    localparam int HALF_BIT = CLK_PER_BIT / 2;
    localparam int CNT_W    = clog2(CLK_PER_BIT) + 1;

    logic [CNT_W-1:0] cnt;

    assign half_tick = (cnt == CNT_W'(HALF_BIT - 1));
    assign full_tick = (cnt == CNT_W'(CLK_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || full_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with parity/framing/overrun reporting and a
// valid/ready output register. Define UART_RX_MAJORITY_EN for 2-of-3 voted sampling.
//
// Handshake: a word is held on data_out/flags while data_valid=1 and is
// consumed on any clock edge where data_valid && data_ready.
module uart_rx_frame #(
    parameter int CLOCK_FREQ = 16000000,
    parameter int BAUD       = 9600,
    parameter int WIDTH      = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);
    import uart_rx_frame_pkg::*;

    localparam int CLK_PER_BIT = CLOCK_FREQ / BAUD;
    localparam int IDX_W       = clog2(WIDTH) + 1;

    logic             sync1;
    logic             rx_s;
    logic             sample;
    rx_state_t        state;
    rx_state_t        state_next;
    logic             timer_clear;
    logic             half_tick;
    logic             full_tick;
    logic [WIDTH-1:0] shift_q;
    logic [IDX_W-1:0] bit_idx;
    logic             perr_q;
    logic             ferr_q;
    logic             frame_done;
    logic             last_data;
    logic             last_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [2:0] vote_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_q <= 3'b111;
        end else begin
            vote_q <= {vote_q[1:0], rx_s};
        end
    end

    assign sample = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);
`else
    assign sample = rx_s;
`endif

    uart_bit_timer #(.CLK_PER_BIT(CLK_PER_BIT)) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (timer_clear),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    assign last_data = (bit_idx == IDX_W'(WIDTH - 1));
    assign last_stop = (bit_idx == IDX_W'(STOP_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (!rx_s) state_next = ST_START;
            ST_START:     if (half_tick) state_next = sample ? ST_IDLE : ST_DATA;
            ST_DATA:      if (full_tick && last_data)
                              state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY:    if (full_tick) state_next = ST_STOP;
            ST_STOP:      if (full_tick && last_stop)
                              state_next = (ferr_q || !sample) ? ST_WAIT_IDLE : ST_IDLE;
            ST_WAIT_IDLE: if (rx_s) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != ST_IDLE);
        timer_clear = (state == ST_IDLE) || (state == ST_START && half_tick);
        frame_done  = (state == ST_STOP) && full_tick && last_stop;
    end

    // bit_idx counts data bits, then is reused to count stop bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_idx <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bit_idx <= '0;
                    perr_q  <= 1'b0;
                    ferr_q  <= 1'b0;
                end
                ST_DATA: if (full_tick) begin
                    shift_q <= {sample, shift_q[WIDTH-1:1]};
                    bit_idx <= last_data ? '0 : bit_idx + IDX_W'(1);
                end
                ST_PARITY: if (full_tick) begin
                    perr_q <= ((^shift_q) ^ sample) != (PARITY == PAR_ODD);
                end
                ST_STOP: if (full_tick) begin
                    bit_idx <= bit_idx + IDX_W'(1);
                    if (!sample) ferr_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A completed frame is dropped only when the held word is not being taken this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (frame_done && data_valid && !data_ready) begin
            overrun <= 1'b1;
        end else if (frame_done) begin
            data_out   <= shift_q;
            data_valid <= 1'b1;
            parity_err <= perr_q;
            frame_err  <= ferr_q | ~sample;
            overrun    <= 1'b0;
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: an 8N1 instance (a) and an 8E1 instance (b) at 16 clocks per bit.
module tb_uart_rx_frame;
    localparam int CPB = 16;
    localparam int W   = 11;

    logic       clk;
    logic       rst_n;
    logic       rx_a, rx_b, ready_a, ready_b;
    logic [7:0] dout_a, dout_b;
    logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b;
    logic       ovr_a, ovr_b, busy_a, busy_b;

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];
    int n_checks = 0;
    int n_pass   = 0;

    uart_rx_frame #(.CLOCK_FREQ(16000000), .BAUD(1000000), .WIDTH(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_a), .data_out(dout_a), .data_valid(valid_a),
        .data_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_frame #(.CLOCK_FREQ(16000000), .BAUD(1000000), .WIDTH(8), .PARITY(2), .STOP_BITS(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_b), .data_out(dout_b), .data_valid(valid_b),
        .data_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] pack(input logic o, input logic f, input logic p, input logic [7:0] d);
        return {o, f, p, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input bit which, input logic v);
        if (which) rx_b = v;
        else rx_a = v;
    endtask

    task automatic send(input bit which, input logic [7:0] data, input bit has_par, input logic par,
                        input int glitch_bit);
        set_rx(which, 1'b0);
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            set_rx(which, data[i]);
            if (i == glitch_bit) begin
                tick(7);
                set_rx(which, ~data[i]);
                tick(1);
                set_rx(which, data[i]);
                tick(8);
            end else begin
                tick(CPB);
            end
        end
        if (has_par) begin
            set_rx(which, par);
            tick(CPB);
        end
        set_rx(which, 1'b1);
        tick(CPB);
    endtask

    task automatic wait_valid_a(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (valid_a !== 1'b1 && cycles < budget);
    endtask

    // scoreboard monitors
    always @(negedge clk) begin : mon_a
        logic [W-1:0] e;
        if (rst_n === 1'b1 && valid_a === 1'b1 && ready_a === 1'b1) begin
            if (exp_a.size() == 0) begin
                n_checks++;
                $display("FAIL a_word: got 0x%0h, expected no word", pack(ovr_a, ferr_a, perr_a, dout_a));
            end else begin
                e = exp_a.pop_front();
                check("a_word", 32'(pack(ovr_a, ferr_a, perr_a, dout_a)), 32'(e));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [W-1:0] e;
        if (rst_n === 1'b1 && valid_b === 1'b1 && ready_b === 1'b1) begin
            if (exp_b.size() == 0) begin
                n_checks++;
                $display("FAIL b_word: got 0x%0h, expected no word", pack(ovr_b, ferr_b, perr_b, dout_b));
            end else begin
                e = exp_b.pop_front();
                check("b_word", 32'(pack(ovr_b, ferr_b, perr_b, dout_b)), 32'(e));
            end
        end
    end

    // directed stimulus
    initial begin
        int         lat;
        logic [7:0] pat;

        rst_n   = 1'b0;
        rx_a    = 1'b1;
        rx_b    = 1'b1;
        ready_a = 1'b1;
        ready_b = 1'b1;
        @(negedge clk);
        check("rst_data_out", dout_a, 8'h00);
        check("rst_valid", valid_a, 1'b0);
        check("rst_flags", {perr_a, ferr_a, ovr_a}, 3'b000);
        check("rst_busy", busy_a, 1'b0);
        check("rst_b_valid_busy", {valid_b, busy_b}, 2'b00);
        tick(2);
        rst_n = 1'b1;
        tick(8);

        // 8N1 0x55: latency, busy already low when the word appears, one-cycle valid
        exp_a.push_back(pack(1'b0, 1'b0, 1'b0, 8'h55));
        fork
            send(1'b0, 8'h55, 1'b0, 1'b0, -1);
            begin
                wait_valid_a(400, lat);
                check("t1_valid_latency", lat, 156);
                check("t1_busy_at_valid", busy_a, 1'b0);
                @(negedge clk);
                check("t1_valid_one_cycle", valid_a, 1'b0);
            end
        join
        tick(CPB);

        // even parity: wrong bit, right bit, right bit on a different pattern
        exp_b.push_back(pack(1'b0, 1'b0, 1'b1, 8'hA3));
        send(1'b1, 8'hA3, 1'b1, 1'b1, -1);
        tick(CPB);
        exp_b.push_back(pack(1'b0, 1'b0, 1'b0, 8'hA3));
        send(1'b1, 8'hA3, 1'b1, 1'b0, -1);
        exp_b.push_back(pack(1'b0, 1'b0, 1'b0, 8'h01));
        send(1'b1, 8'h01, 1'b1, 1'b1, -1);
        tick(CPB);
        check("t2_all_words", exp_b.size(), 0);

        // break: one 0x00 word with frame_err, then nothing until a fresh start bit
        exp_a.push_back(pack(1'b0, 1'b1, 1'b0, 8'h00));
        rx_a = 1'b0;
        tick(15 * CPB);
        check("t3_busy_in_break", busy_a, 1'b1);
        check("t3_one_word", exp_a.size(), 0);
        tick(5 * CPB);
        rx_a = 1'b1;
        tick(2 * CPB);
        check("t3_idle_after_break", busy_a, 1'b0);
        exp_a.push_back(pack(1'b0, 1'b0, 1'b0, 8'hC3));
        send(1'b0, 8'hC3, 1'b0, 1'b0, -1);
        tick(CPB);
        check("t3_resync", exp_a.size(), 0);

        // short low glitch is a false start
        rx_a = 1'b0;
        tick(4);
        rx_a = 1'b1;
        tick(3 * CPB);
        check("t4_false_start_idle", busy_a, 1'b0);
        tick(10 * CPB);
        check("t4_no_valid", valid_a, 1'b0);
`ifdef UART_RX_MAJORITY_EN
        exp_a.push_back(pack(1'b0, 1'b0, 1'b0, 8'h3C));
        send(1'b0, 8'h3C, 1'b0, 1'b0, 2);
        tick(CPB);
        check("t4_majority_word", exp_a.size(), 0);
`endif

        // overrun: 0x11 held, 0x22 dropped
        ready_a = 1'b0;
        exp_a.push_back(pack(1'b1, 1'b0, 1'b0, 8'h11));
        send(1'b0, 8'h11, 1'b0, 1'b0, -1);
        send(1'b0, 8'h22, 1'b0, 1'b0, -1);
        tick(CPB);
        check("t5_held_data", dout_a, 8'h11);
        check("t5_overrun", ovr_a, 1'b1);
        check("t5_valid_held", valid_a, 1'b1);
        ready_a = 1'b1;
        tick(1);
        ready_a = 1'b0;
        @(negedge clk);
        check("t5_valid_drop", valid_a, 1'b0);
        tick(2 * CPB);
        check("t5_no_second_word", exp_a.size(), 0);
        ready_a = 1'b1;

        // reset mid-DATA of 0x7E, then a clean 0x81
        pat  = 8'h7E;
        rx_a = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_a = pat[i];
            tick(CPB);
        end
        check("t6_busy_mid_frame", busy_a, 1'b1);
        rst_n = 1'b0;
        rx_a  = 1'b1;
        #2;
        check("t6_rst_data_out", dout_a, 8'h00);
        check("t6_rst_valid", valid_a, 1'b0);
        check("t6_rst_flags", {perr_a, ferr_a, ovr_a}, 3'b000);
        check("t6_rst_busy", busy_a, 1'b0);
        tick(4);
        rst_n = 1'b1;
        tick(2 * CPB);
        exp_a.push_back(pack(1'b0, 1'b0, 1'b0, 8'h81));
        send(1'b0, 8'h81, 1'b0, 1'b0, -1);
        tick(CPB);
        check("t6_word_after_reset", exp_a.size(), 0);
        check("final_b_queue", exp_b.size(), 0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
